// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, flush-to-bubble and a
// saturating starvation counter. up_ready comes straight from a flop.
//
// state | meaning
// EMPTY | no entry held; dn_data shows NOP_VAL
// ONE   | main holds the oldest (only) entry
// FULL  | main holds the oldest entry, skid the next; up_ready low
module pipe_stage_skid_reg #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int                CNT_W   = 16
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic                up_ready_q;
  logic [CNT_W-1:0]    bubble_q;
  logic                accept, drain;

  assign accept     = up_valid & up_ready_q;
  assign drain      = dn_valid & dn_ready;
  assign occ        = state_q;
  assign dn_valid   = (state_q != EMPTY);
  assign dn_data    = main_q;
  assign up_ready   = up_ready_q;
  assign bubble_cnt = bubble_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = up_data;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_d = up_data;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = up_data;
          end else if (drain) begin
            state_d = EMPTY;
            main_d  = NOP_VAL;
          end
        end
        FULL: begin
          if (drain) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = NOP_VAL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q    <= EMPTY;
      main_q     <= NOP_VAL;
      skid_q     <= NOP_VAL;
      up_ready_q <= 1'b1;
      bubble_q   <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      up_ready_q <= (state_d != FULL);
      // starvation counts regardless of flush; saturates instead of wrapping
      if (dn_ready && !dn_valid && (bubble_q != {CNT_W{1'b1}}))
        bubble_q <= bubble_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised, elastic pipeline-stage register that replaces fixed stall-vector stage registers between CPU pipeline stages (e.g. EXE→MEM).
- Carries an opaque DATA_W-bit payload bundle with valid/ready handshakes on both sides.
- A 2-entry skid buffer keeps up_ready registered, so back-pressure does not form a combinational path through the stage.
- Supports flush with NOP-bubble injection and keeps a saturating starvation counter for performance analysis.

Parameters:
DATA_W, 32, payload width in bits (the concatenated stage bundle).
NOP_VAL, {DATA_W{1'b0}}, payload driven on dn_data when empty, after reset and after flush.
CNT_W, 16, width of bubble_cnt.

Ports:
cpu_clk_50M  in  1  single clock; all state updates on rising edge.
cpu_rst  in  1  reset; synchronous, active-high.
flush  in  1  discard all held entries (exception/eret redirect).
up_valid  in  1  upstream beat present.
up_ready  out  1  stage can accept a beat; driven directly from a flop.
up_data  in  DATA_W  upstream payload.
dn_valid  out  1  stage holds a beat for downstream.
dn_ready  in  1  downstream accepts the beat.
dn_data  out  DATA_W  payload of oldest held entry, or NOP_VAL when empty.
occ  out  2  current entry count: 0, 1 or 2.
bubble_cnt  out  CNT_W  count of cycles with dn_ready=1 and dn_valid=0; saturating.

Behaviour:
- Definitions: accept = up_valid & up_ready; drain = dn_valid & dn_ready.
- Storage: main register (oldest entry, drives dn_data) and skid register (second entry). Order is strictly FIFO.
- States are encoded by occ:
  - EMPTY (0): dn_valid=0, dn_data=NOP_VAL.
  - ONE (1): main valid.
  - FULL (2): main and skid valid.
- dn_valid = (occ != 0), combinational from occ.
- up_ready flop, next value = (next_occ != 2). It is 0 only in FULL.
- Transitions, evaluated when cpu_rst=0 and flush=0:
  - EMPTY, accept → ONE; main <= up_data. A drain is impossible in EMPTY.
  - ONE, accept & drain → ONE; main <= up_data (pass-through, 1-cycle latency).
  - ONE, accept only → FULL; skid <= up_data; up_ready <= 0.
  - ONE, drain only → EMPTY; main <= NOP_VAL.
  - FULL, drain → ONE; main <= skid; skid <= NOP_VAL; up_ready <= 1. No accept is possible in FULL because up_ready=0.
  - No event → hold all state.
- Latency: a beat accepted into an EMPTY stage appears on dn_data/dn_valid the next cycle. Throughput is 1 beat/cycle while dn_ready stays high.
- Flush, priority below reset:
  - Next cycle: occ=0, main=skid=NOP_VAL, up_ready=1.
  - A beat offered or drained in the flush cycle is discarded. Downstream must ignore drain in the flush cycle.
  - bubble_cnt is not affected by flush.
- Reset (cpu_rst=1, sampled at the clock edge): occ=0, main=skid=NOP_VAL, dn_valid=0, dn_data=NOP_VAL, up_ready=1, bubble_cnt=0. Reset mid-operation drops all held entries.
- bubble_cnt:
  - Increments by 1 on each non-reset cycle where dn_ready=1 and dn_valid=0, including the flush cycle.
  - Saturates at 2^CNT_W-1 with no wrap. Cleared only by reset.
- up_data is sampled only on accept. Payload values outside accept cycles have no effect.
- Payload is opaque: no width conversion and no field decoding.

Test Plan:
- Reset: assert cpu_rst 2 cycles with up_valid=1, up_data=0xA5A5A5A5 → occ=0, dn_valid=0, dn_data=NOP_VAL, up_ready=1, bubble_cnt=0 after release.
- Streaming: dn_ready=1, feed 0x1,0x2,0x3 on consecutive cycles → dn_data 0x1,0x2,0x3 on the following cycles, occ stays 1, up_ready stays 1.
- Back-pressure: dn_ready=0, feed 0x10,0x11,0x12 → occ=2 after 0x11, up_ready=0, 0x12 held upstream. Raise dn_ready → outputs 0x10,0x11,0x12 in order with no loss or duplication.
- Flush while FULL, with up_valid=1 carrying 0x99 in the same cycle → next cycle occ=0, dn_data=NOP_VAL, up_ready=1. 0x99 never appears on dn_data.
- Starvation counter: CNT_W=2, dn_ready=1, up_valid=0 for 5 cycles → bubble_cnt 1,2,3,3,3. A flush leaves it at 3; cpu_rst clears it to 0.
- Random: 10k cycles of random up_valid/dn_ready/flush, checked against a FIFO scoreboard → order preserved, occ≤2, up_ready never 1 when occ=2.
